// File: rtl/mac_mul_block_pipe.sv
// Two-stage unsigned block multiplier: A (1, 2 or 4 blocks) times B1, with a
// valid/ready handshake and a sticky flag for reserved configurations.
module mac_mul_block_pipe #(
   parameter int MAC_CONF_WIDTH = 2,
   parameter int MAC_MIN_WIDTH  = 8,
   parameter int MAC_MULT_WIDTH = 2*MAC_MIN_WIDTH,
   parameter int MAC_INT_WIDTH  = 5*MAC_MIN_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [4*MAC_MIN_WIDTH-1:0] A,
   input  logic [MAC_MIN_WIDTH-1:0]   B1,
   input  logic [MAC_CONF_WIDTH-1:0]  cfg,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [MAC_INT_WIDTH-1:0]   C,
   output logic                       cfg_err
);

   localparam int N    = MAC_MIN_WIDTH;
   localparam int NSEG = 5;

   typedef enum logic [1:0] {
      MODE_SINGLE = 2'b00,
      MODE_DUAL   = 2'b01,
      MODE_QUAD   = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_e;

   logic                      advance;
   logic                      accept;

   mode_e                     mode_d;
   logic [MAC_MULT_WIDTH-1:0] pp_d [4];
   logic                      cfg_err_d;
   logic [MAC_INT_WIDTH-1:0]  c_d;

   logic                      s1_valid_q;
   mode_e                     s1_mode_q;
   logic [MAC_MULT_WIDTH-1:0] pp_q [4];
   logic                      out_valid_q;
   logic [MAC_INT_WIDTH-1:0]  c_q;
   logic                      cfg_err_q;

   logic [MAC_MULT_WIDTH-1:0] term_s [4];
   logic [N-1:0]              lo_s [NSEG];
   logic [N-1:0]              hi_s [NSEG];
   logic [N:0]                seg_s;
   logic                      carry_s;
   logic [NSEG*N-1:0]         sum_s;

   // Both stages move only together, so a stalled output also stalls the input.
   assign advance   = en & (~out_valid_q | out_ready);
   assign accept    = in_valid & advance;
   assign in_ready  = advance;
   assign out_valid = out_valid_q;
   assign C         = c_q;
   assign cfg_err   = cfg_err_q;

   // Stage-1 inputs: mode decode, the four block partial products, error flag.
   always_comb begin
      mode_d = MODE_RSVD;
      case (cfg)
         MAC_CONF_WIDTH'(0): mode_d = MODE_SINGLE;
         MAC_CONF_WIDTH'(1): mode_d = MODE_DUAL;
         MAC_CONF_WIDTH'(2): mode_d = MODE_QUAD;
         default:            mode_d = MODE_RSVD;
      endcase
      for (int i = 0; i < 4; i++) begin
         pp_d[i] = MAC_MULT_WIDTH'(A[i*N +: N]) * MAC_MULT_WIDTH'(B1);
      end
      cfg_err_d = cfg_err_q | (accept & (mode_d == MODE_RSVD));
   end

   // Stage-2 combine: single mode places A1*B1 at weight 0; unused terms are zeroed
   // before the segment carry chain and the final carry is dropped.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         term_s[i] = '0;
      end
      case (s1_mode_q)
         MODE_SINGLE: term_s[0] = pp_q[1];
         MODE_DUAL: begin
            term_s[0] = pp_q[0];
            term_s[1] = pp_q[1];
         end
         MODE_QUAD: begin
            for (int i = 0; i < 4; i++) begin
               term_s[i] = pp_q[i];
            end
         end
         default: term_s[0] = '0;
      endcase
      for (int k = 0; k < NSEG; k++) begin
         lo_s[k] = '0;
         hi_s[k] = '0;
      end
      for (int k = 0; k < 4; k++) begin
         lo_s[k]   = term_s[k][N-1:0];
         hi_s[k+1] = term_s[k][2*N-1:N];
      end
      sum_s   = '0;
      seg_s   = '0;
      carry_s = 1'b0;
      for (int k = 0; k < NSEG; k++) begin
         seg_s = {1'b0, lo_s[k]} + {1'b0, hi_s[k]} + {{N{1'b0}}, carry_s};
         sum_s[k*N +: N] = seg_s[N-1:0];
         carry_s = seg_s[N];
      end
      c_d = MAC_INT_WIDTH'(sum_s);
   end

   // Pipeline state; reset wins over enable and flushes in-flight beats.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_mode_q   <= MODE_SINGLE;
         for (int i = 0; i < 4; i++) begin
            pp_q[i] <= '0;
         end
         out_valid_q <= 1'b0;
         c_q         <= '0;
         cfg_err_q   <= 1'b0;
      end else begin
         cfg_err_q <= cfg_err_d;
         if (advance) begin
            s1_valid_q  <= in_valid;
            s1_mode_q   <= mode_d;
            pp_q        <= pp_d;
            out_valid_q <= s1_valid_q;
            c_q         <= c_d;
         end
      end
   end

endmodule

// File: tb/tb_mac_mul_block_pipe.sv
// Bench for mac_mul_block_pipe: directed literal cases plus randomized traffic
// checked every cycle against a queue-based product model.
module tb_mac_mul_block_pipe;

   logic        clk = 1'b0;
   logic        rst, en, in_valid, in_ready, out_valid, out_ready, cfg_err;
   logic [31:0] A;
   logic [7:0]  B1;
   logic [1:0]  cfg;
   logic [39:0] C;

   int          checks = 0;
   int          errors = 0;
   logic [39:0] exp_q[$];
   logic        model_err = 1'b0;
   logic        mon_on = 1'b0;
   logic        prev_hold = 1'b0;
   logic        prev_ov = 1'b0;
   logic [39:0] prev_c = 40'd0;

   always #5 clk = ~clk;

   mac_mul_block_pipe dut (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B1(B1), .cfg(cfg), .out_valid(out_valid), .out_ready(out_ready),
      .C(C), .cfg_err(cfg_err)
   );

   function automatic logic [39:0] ref_product(input logic [31:0] a, input logic [7:0] b,
                                               input logic [1:0] c);
      logic [63:0] p;
      case (c)
         2'd0:    p = 64'(a[15:8]) * 64'(b);
         2'd1:    p = 64'(a[15:0]) * 64'(b);
         2'd2:    p = 64'(a) * 64'(b);
         default: p = 64'd0;
      endcase
      return p[39:0];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every cycle: handshake rule, sticky flag, stall stability, in-order results.
   always @(negedge clk) begin
      logic exp_rdy;
      if (mon_on) begin
         exp_rdy = en & (~out_valid | out_ready);
         chk("in_ready", 64'(in_ready), 64'(exp_rdy));
         chk("cfg_err", 64'(cfg_err), 64'(model_err));
         if (prev_hold) begin
            chk("hold_out_valid", 64'(out_valid), 64'(prev_ov));
            chk("hold_C", 64'(C), 64'(prev_c));
         end
         if (rst) begin
            exp_q.delete();
            model_err = 1'b0;
         end else begin
            if (out_valid && exp_rdy) begin
               if (exp_q.size() == 0) chk("unexpected_out", 64'(out_valid), 64'd0);
               else                   chk("C_result", 64'(C), 64'(exp_q.pop_front()));
            end
            if (in_valid && exp_rdy) begin
               exp_q.push_back(ref_product(A, B1, cfg));
               if (cfg == 2'b11) model_err = 1'b1;
            end
         end
         prev_hold = !rst && !exp_rdy;
         prev_ov   = out_valid;
         prev_c    = C;
      end
   end

   task automatic send(input logic [31:0] a, input logic [7:0] b, input logic [1:0] c);
      int n;
      in_valid = 1'b1;
      A = a;
      B1 = b;
      cfg = c;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (n >= 50) chk("send_timeout", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic expect_out(input string name, input logic [39:0] exp);
      @(posedge clk);
      #1;
      chk({name, "_valid"}, 64'(out_valid), 64'd1);
      chk(name, 64'(C), 64'(exp));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      A = 32'd0; B1 = 8'd0; cfg = 2'd0;
      idle(2);
      chk("rst_C", 64'(C), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_cfg_err", 64'(cfg_err), 64'd0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      mon_on = 1'b1;

      // Literal products across the modes and the reserved config.
      send(32'hAAAAFFAA, 8'hFF, 2'd0);
      expect_out("single", 40'h00000_0FE01);
      send(32'hDEAD1234, 8'h56, 2'd1);
      expect_out("dual", 40'h000_0061D78);
      send(32'hFFFFFFFF, 8'hFF, 2'd2);
      expect_out("quad", 40'hFE_FFFFFF01);
      send(32'h12345678, 8'h9A, 2'd3);
      expect_out("reserved", 40'd0);
      chk("reserved_cfg_err", 64'(cfg_err), 64'd1);
      send(32'h00000300, 8'h05, 2'd0);
      expect_out("after_reserved", 40'h0F);
      chk("sticky_cfg_err", 64'(cfg_err), 64'd1);
      idle(2);

      // Downstream stall with beats queued behind it.
      out_ready = 1'b0;
      send(32'h00001000, 8'h10, 2'd0);
      send(32'h00000102, 8'h03, 2'd1);
      chk("stall_first", 64'(C), 64'h100);
      fork
         send(32'h01000000, 8'h02, 2'd2);
         begin
            repeat (3) begin
               @(negedge clk);
               chk("stall_in_ready", 64'(in_ready), 64'd0);
               chk("stall_C", 64'(C), 64'h100);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      chk("stall_second", 64'(C), 64'h306);
      expect_out("stall_third", 40'h0002000000);
      idle(2);

      // Reset with two beats in flight; the sticky flag clears here.
      send(32'h00001100, 8'h11, 2'd0);
      send(32'h00002200, 8'h22, 2'd0);
      rst = 1'b1;
      idle(1);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_C", 64'(C), 64'd0);
      chk("flush_cfg_err", 64'(cfg_err), 64'd0);
      rst = 1'b0;
      repeat (3) begin
         idle(1);
         chk("flush_no_stale", 64'(out_valid), 64'd0);
      end

      // Enable low freezes everything, then traffic resumes in order.
      send(32'h00002000, 8'h04, 2'd0);
      en = 1'b0;
      in_valid = 1'b1; A = 32'h00000300; B1 = 8'h03; cfg = 2'd0;
      repeat (4) begin
         @(negedge clk);
         chk("en_low_in_ready", 64'(in_ready), 64'd0);
         chk("en_low_out_valid", 64'(out_valid), 64'd0);
      end
      @(posedge clk);
      #1;
      en = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("en_resume_valid", 64'(out_valid), 64'd1);
      chk("en_resume_C", 64'(C), 64'h80);
      expect_out("en_resume_second", 40'h09);

      // Randomized traffic with back-pressure and enable gaps.
      repeat (400) begin
         @(posedge clk);
         #1;
         in_valid  = 1'($urandom_range(0, 1));
         A         = $urandom;
         B1        = 8'($urandom);
         cfg       = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         out_ready = ($urandom_range(0, 3) != 0);
         en        = ($urandom_range(0, 7) != 0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0; en = 1'b1; out_ready = 1'b1;
      idle(4);
      chk("drain_empty", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
